// File: rtl/lut_layer_pkg.sv
// lut_layer_pkg: shared state enum and width/connectivity helpers for the LUT layer sequencer
package lut_layer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    localparam int CONN_MAX_W = 4096;

    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic int addr_w(input int fan_in, input int in_bits);
        return fan_in * in_bits;
    endfunction

    function automatic int conn_idx(input logic [CONN_MAX_W-1:0] conn, input int n, input int k,
                                    input int fan_in, input int iw);
        return int'((conn >> (iw * (n * fan_in + k))) & CONN_MAX_W'((1 << iw) - 1));
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// lut_table_ram: single-write single-read truth-table memory with registered read
module lut_table_ram #(
    parameter int AW = 11,
    parameter int DW = 2,
    parameter int DEPTH = 2048
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    (* rom_style = "distributed" *) logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_layer_sequencer.sv
// lut_layer_sequencer: evaluates a layer of LUT neurons one per cycle from a shared truth-table RAM
module lut_layer_sequencer import lut_layer_pkg::*; #(
    parameter int NUM_INPUTS  = 16,
    parameter int IN_BITS     = 2,
    parameter int FAN_IN      = 4,
    parameter int NUM_NEURONS = 8,
    parameter int OUT_BITS    = 2,
    parameter logic [NUM_NEURONS*FAN_IN*cnt_w(NUM_INPUTS)-1:0] CONN = '0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [NUM_INPUTS*IN_BITS-1:0]              in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0]            out_data,
    input  logic                                       cfg_we,
    input  logic [cnt_w(NUM_NEURONS)+FAN_IN*IN_BITS-1:0] cfg_addr,
    input  logic [OUT_BITS-1:0]                        cfg_data,
    output logic                                       cfg_busy
);

    localparam int IW = cnt_w(NUM_INPUTS);
    localparam int NW = cnt_w(NUM_NEURONS);
    localparam int A  = addr_w(FAN_IN, IN_BITS);

    state_t                          state_q;
    logic [NW-1:0]                   cnt_q;
    logic [NW-1:0]                   rd_n_q;
    logic                            rd_v_q;
    logic                            out_valid_q;
    logic [NUM_INPUTS*IN_BITS-1:0]   in_q;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_q;
    logic [A-1:0]                    gath [NUM_NEURONS];
    logic [OUT_BITS-1:0]             rdata;

    // Connectivity is fixed at elaboration, so each neuron's address is plain wiring into in_q
    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_n
        for (genvar k = 0; k < FAN_IN; k++) begin : g_k
            localparam int IDX = conn_idx(CONN_MAX_W'(CONN), n, k, FAN_IN, IW);
            if (IDX >= NUM_INPUTS) begin : g_bad
                $error("lut_layer_sequencer: CONN index out of range");
                assign gath[n][k*IN_BITS +: IN_BITS] = '0;
            end else begin : g_ok
                assign gath[n][k*IN_BITS +: IN_BITS] = in_q[IDX*IN_BITS +: IN_BITS];
            end
        end
    end

    lut_table_ram #(
        .AW(NW + A),
        .DW(OUT_BITS),
        .DEPTH(NUM_NEURONS << A)
    ) u_ram (
        .clk(clk),
        .we_i(cfg_we && state_q == IDLE),
        .waddr_i(cfg_addr),
        .wdata_i(cfg_data),
        .raddr_i({cnt_q, gath[cnt_q]}),
        .rdata_o(rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            rd_v_q <= state_q == RUN;
            rd_n_q <= cnt_q;
            if (rd_v_q) out_q[rd_n_q*OUT_BITS +: OUT_BITS] <= rdata;
            case (state_q)
                IDLE: if (in_valid) begin
                    in_q    <= in_data;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: if (cnt_q == NW'(NUM_NEURONS - 1)) state_q <= DRAIN;
                     else cnt_q <= cnt_q + 1'b1;
                DRAIN: begin
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == IDLE;
    assign cfg_busy  = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// tb_lut_layer_sequencer: directed and streaming checks of the LUT layer sequencer
module tb_lut_layer_sequencer;

    localparam logic [127:0] CONN_P = 128'hb5a9c4f1_663380ef_7295dcba_43210000;
    localparam logic [31:0]  GATH   = 32'h0008_0430;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        cfg_we = 1'b0;
    logic [10:0] cfg_addr = '0;
    logic [1:0]  cfg_data = '0;
    logic        cfg_busy;

    logic [127:0] conn_v = CONN_P;
    logic [1:0]   tbl [2048];
    int           n_vec = 0;
    int           n_bad = 0;

    lut_layer_sequencer #(
        .NUM_INPUTS(16),
        .IN_BITS(2),
        .FAN_IN(4),
        .NUM_NEURONS(8),
        .OUT_BITS(2),
        .CONN(CONN_P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .cfg_busy(cfg_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] ref_out(input logic [31:0] din);
        logic [15:0] r;
        logic [7:0]  a;
        logic [3:0]  idx;
        r = '0;
        for (int n = 0; n < 8; n++) begin
            a = '0;
            for (int k = 0; k < 4; k++) begin
                idx = conn_v[(n*4+k)*4 +: 4];
                a[k*2 +: 2] = din[int'(idx)*2 +: 2];
            end
            r[n*2 +: 2] = tbl[n*256 + int'(a)];
        end
        return r;
    endfunction

    task automatic load_tbl();
        cfg_we = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            cfg_addr = 11'(i);
            cfg_data = tbl[i];
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic send(input string tag, input logic [31:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 40) begin
            tick();
            t++;
        end
        chk({tag, "_acc"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [15:0] exp);
        int t = 0;
        while (!out_valid && t < 40) begin
            tick();
            t++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        int          acc;
        int          hs;
        int          cyc;
        logic        pend;
        logic [15:0] q[$];
        logic [15:0] e;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);

        for (int i = 0; i < 2048; i++) tbl[i] = 2'b00;
        tbl[0]     = 2'b10;
        tbl[11'h339] = 2'b11;
        load_tbl();

        in_valid = 1'b1;
        in_data  = '0;
        chk("single_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd10);
        recv("single", 16'h0002);

        send("gather", GATH);
        recv("gather", 16'h00C2);

        send("bp1", GATH);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        in_valid = 1'b1;
        in_data  = '0;
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h00C2);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_post_valid", 32'(out_valid), 32'd0);
        chk("bp_post_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_second_acc", 32'(cfg_busy), 32'd1);
        recv("bp2", 16'h0002);

        send("gate_run", 32'd0);
        tick();
        tick();
        cfg_we   = 1'b1;
        cfg_addr = 11'd0;
        cfg_data = 2'b01;
        chk("gate_busy", 32'(cfg_busy), 32'd1);
        tick();
        cfg_we = 1'b0;
        recv("gate_run", 16'h0002);
        send("gate_old", 32'd0);
        recv("gate_old", 16'h0002);

        in_valid = 1'b1;
        in_data  = '0;
        cfg_we   = 1'b1;
        cfg_addr = 11'd0;
        cfg_data = 2'b01;
        chk("cfg_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        tbl[0]   = 2'b01;
        recv("cfg_with_in", 16'h0001);

        send("rst_run", GATH);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstrun_in_ready", 32'(in_ready), 32'd1);
        chk("rstrun_out_valid", 32'(out_valid), 32'd0);
        chk("rstrun_out_data", 32'(out_data), 32'd0);
        chk("rstrun_busy", 32'(cfg_busy), 32'd0);
        send("resub", GATH);
        recv("resub", 16'h00C1);

        for (int i = 0; i < 2048; i++) tbl[i] = 2'($urandom);
        load_tbl();
        acc  = 0;
        hs   = 0;
        cyc  = 0;
        pend = 1'b0;
        while (hs < 100 && cyc < 6000) begin
            if (!pend && acc < 100 && $urandom_range(0, 3) != 0) begin
                pend    = 1'b1;
                in_data = $urandom;
            end
            in_valid  = pend;
            out_ready = $urandom_range(0, 2) != 0;
            if (in_valid && in_ready) begin
                q.push_back(ref_out(in_data));
                acc++;
                pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                e = q.size() != 0 ? q.pop_front() : 16'hxxxx;
                chk("stream", 32'(out_data), 32'(e));
                hs++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_out_hs", 32'(hs), 32'd100);
        chk("stream_in_hs", 32'(acc), 32'd100);
        chk("stream_left", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
